// File: rtl/nibble_pkg.sv
// nibble_pkg
// Shared definitions for the byte deserializer and the downstream nibble-swap
// stage: the deserializer FSM state encoding and the byte/counter widths.
package nibble_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

endpackage

// File: rtl/byte_deserializer.sv
// byte_deserializer
// Recovers bytes from a qualified serial bit stream framed as
//   start(0), 8 data bits, optional even-parity bit, stop(1).
// Bits are consumed only on edges where sin_valid=1; all state holds otherwise.
//
// Ports:
//   clk        : clock, rising edge active
//   reset      : asynchronous, active-high reset
//   sin        : serial data bit
//   sin_valid  : qualifies sin
//   data_out   : last correctly framed byte (registered)
//   data_valid : one-cycle strobe for a new data_out
//   parity_err : parity result, only non-zero alongside data_valid
//   frame_err  : one-cycle strobe when the stop bit was sampled as 0
//
// Parameters:
//   LSB_FIRST  : 1 = data bits arrive LSB first, 0 = MSB first
//   PARITY_EN  : 1 = a parity bit follows the data bits
module byte_deserializer
    import nibble_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BYTE_W-1:0]  shift_q;
    logic               par_q;
    logic [BYTE_W-1:0]  data_out_q;
    logic               data_valid_q;
    logic               parity_err_q;
    logic               frame_err_q;

    // Destination bit of the current data bit within the byte.
    logic [CNT_W-1:0]   bit_idx;
    logic [BYTE_W-1:0]  shift_d;

    assign bit_idx = LSB_FIRST ? cnt_q : (CNT_W'(BYTE_W - 1) - cnt_q);

    always_comb begin
        shift_d          = shift_q;
        shift_d[bit_idx] = sin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses: they drop on the next edge
            // whether or not that edge carries a valid bit.
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (sin_valid) begin
                case (state_q)
                    IDLE: begin
                        if (!sin) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            // Restart the parity accumulator so nothing from
                            // an earlier frame leaks into this one.
                            par_q   <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_q <= shift_d;
                        par_q   <= par_q ^ sin;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                            state_q <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_q   <= par_q ^ sin;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (sin) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                            // Even parity: data bits plus parity bit XOR to 0.
                            parity_err_q <= PARITY_EN ? par_q : 1'b0;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/byte_deserializer.md
BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

Interface
REQ-001 Parameter LSB_FIRST, default 1: 1 means data bits arrive LSB first; 0 means MSB first.
REQ-002 Parameter PARITY_EN, default 1: 1 means a parity bit follows the data bits; 0 means there is no parity bit.
REQ-003 clk  input  1  Single clock; all state changes on the rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 sin  input  1  Serial data bit.
REQ-006 sin_valid  input  1  Qualifies sin; the block samples sin only on edges where sin_valid=1.
REQ-007 data_out  output  8  Last correctly framed byte; drives the downstream nibble-swap stage's byte input.
REQ-008 data_valid  output  1  One-cycle strobe for a new data_out; drives the downstream swap enable.
REQ-009 parity_err  output  1  Parity result for the byte; meaningful only while data_valid=1, otherwise 0.
REQ-010 frame_err  output  1  One-cycle strobe when the stop bit is sampled as 0.

Function
REQ-011 The frame SHALL be: start bit (0), 8 data bits, parity bit (only if PARITY_EN=1, even parity over the data bits), stop bit (1).
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL hold its state and all registers on any edge where sin_valid=0.
REQ-013 IDLE: a sampled 0 SHALL move to DATA and clear the bit counter; a sampled 1 SHALL remain in IDLE.
REQ-014 DATA: each sampled bit SHALL be shifted into an 8-bit shift register, at bit index count if LSB_FIRST=1 or 7-count if LSB_FIRST=0.
REQ-015 DATA: a 3-bit counter SHALL increment per sampled bit; after the 8th bit (count=7) the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-016 A running XOR of the data bits SHALL be kept; in PARITY the sampled bit SHALL be XORed into it and the FSM SHALL go to STOP.
REQ-017 STOP with a sampled 1: on the same edge, data_out SHALL load the shift register, data_valid=1 for exactly one cycle, parity_err SHALL equal the XOR result (forced 0 if PARITY_EN=0), and the FSM SHALL go to IDLE.
REQ-018 STOP with a sampled 0: frame_err=1 for exactly one cycle; data_out unchanged; data_valid=0; FSM to IDLE.
REQ-019 Latency SHALL be one edge: the strobes are visible in the cycle after the edge that samples the stop bit.
REQ-020 Back-to-back frames SHALL be supported: a start bit sampled on the edge immediately after the stop bit SHALL be accepted.
REQ-021 data_valid and frame_err SHALL never both be 1 in the same cycle.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from sin or sin_valid to any output.

Reset
REQ-023 While reset=1, at any point including mid-frame: FSM=IDLE; counter, shift register and parity accumulator=0; data_out=8'h00; data_valid, parity_err and frame_err=0.
REQ-024 After reset deasserts, the first frame SHALL be decoded correctly with no partial-frame carryover.

Structure
REQ-025 Shared package nibble_pkg SHALL hold the FSM state enum (2 bits), BYTE_W=8 and CNT_W=3.
REQ-026 The block SHALL be a single module with no sub-module; the bit counter and parity XOR are inline.

Verification
REQ-027 LSB_FIRST=1, frame 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1 -> data_out=8'hA5, data_valid for 1 cycle, parity_err=0.
REQ-028 Same frame with parity bit 1 -> data_out=8'hA5, data_valid=1, parity_err=1.
REQ-029 Prior byte 8'hA5, then a frame for 8'h3C with stop bit 0 -> frame_err for 1 cycle, data_valid=0, data_out stays 8'hA5.
REQ-030 Frame 8'h5A with sin_valid=0 inserted for 3 cycles after data bit 4 -> data_out=8'h5A, data_valid once, no other strobes.
REQ-031 reset asserted after 4 data bits, then a full frame 8'h3C -> all outputs 0 during reset, then data_out=8'h3C with parity_err=0.
REQ-032 LSB_FIRST=0, PARITY_EN=0, frames 8'h12 and 8'h34 back-to-back -> two data_valid pulses 10 sampled edges apart, with data_out 8'h12 then 8'h34.
